// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake bundle between the calculator control FSM and the
// iterative multiplier.
interface seq_multiplier_if #(
  parameter int A_W = 10,
  parameter int B_W = 10,
  parameter int P_W = 20
);
  logic           start;
  logic           signed_mode;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           busy;
  logic           done;
  logic [P_W-1:0] product;
  logic           overflow;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product, overflow
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: one multiplier bit per clock on operand
// magnitudes, sign applied at the end, optional truncation with overflow flag.
module seq_multiplier #(
  parameter int A_W = 10,
  parameter int B_W = 10,
  parameter int P_W = 20
) (
  input  logic clk,
  input  logic rst,
  seq_multiplier_if.slave bus
);
  localparam int N     = A_W + B_W;
  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(B_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [N-1:0]     mcand;
  logic [B_W-1:0]   mplier;
  logic [N-1:0]     acc;
  logic             neg;
  logic             sm;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   product_q;
  logic             ovf_q;
  logic             done_q;

  logic [A_W-1:0]   a_mag;
  logic [B_W-1:0]   b_mag;
  logic [N-1:0]     full;
  logic signed [N-1:0] full_hi;
  logic             ovf;

  // Magnitudes of the most negative values still fit as unsigned A_W/B_W bits.
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.signed_mode && bus.a[A_W-1]) a_mag = -bus.a;
    if (bus.signed_mode && bus.b[B_W-1]) b_mag = -bus.b;
  end

  // Signed fit: every bit from P_W-1 upward must equal the sign bit.
  always_comb begin
    full    = neg ? -acc : acc;
    full_hi = $signed(full) >>> (P_W - 1);
    if (sm) ovf = (full_hi != '0) && (full_hi != '1);
    else    ovf = (full >> P_W) != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      sm        <= 1'b0;
      cnt       <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= N'(a_mag);
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            sm     <= bus.signed_mode;
            neg    <= bus.signed_mode & (bus.a[A_W-1] ^ bus.b[B_W-1]);
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= FINISH;
        end
        FINISH: begin
          product_q <= full[P_W-1:0];
          ovf_q     <= ovf;
          done_q    <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.product  = product_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Drives a full-width (P_W=20) and a truncating (P_W=12) multiplier with the
// same operand stream and checks both against an integer-arithmetic model.
module tb_seq_multiplier;
  localparam int A_W = 10;
  localparam int B_W = 10;

  logic clk = 1'b0;
  logic rst;
  int   passes = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.A_W(A_W), .B_W(B_W), .P_W(20)) m0 ();
  seq_multiplier_if #(.A_W(A_W), .B_W(B_W), .P_W(12)) m1 ();

  assign m1.start       = m0.start;
  assign m1.signed_mode = m0.signed_mode;
  assign m1.a           = m0.a;
  assign m1.b           = m0.b;

  seq_multiplier #(.A_W(A_W), .B_W(B_W), .P_W(20)) dut  (.clk(clk), .rst(rst), .bus(m0.slave));
  seq_multiplier #(.A_W(A_W), .B_W(B_W), .P_W(12)) dut_t (.clk(clk), .rst(rst), .bus(m1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Exact product by plain integer arithmetic, then reduced to pw bits.
  function automatic void model(input logic [9:0] a, input logic [9:0] b, input bit s,
                                input int pw, output logic [19:0] p, output bit ov);
    longint va, vb, prod, m;
    va   = s ? longint'($signed(a)) : longint'(a);
    vb   = s ? longint'($signed(b)) : longint'(b);
    prod = va * vb;
    m    = longint'(1) << pw;
    p    = 20'(prod & (m - 1));
    ov   = s ? (prod < -(m / 2) || prod >= (m / 2)) : (prod >= m);
  endfunction

  // Entered at a negedge with the DUTs idle (or in their done cycle).
  // A second start with other operands is pulsed mid-run; with hold=1 start
  // stays high throughout so the next call is accepted back-to-back.
  task automatic op(input string tag, input logic [9:0] a, input logic [9:0] b,
                    input bit s, input bit hold);
    logic [19:0] p0, p1;
    bit          o0, o1, ok;
    model(a, b, s, 20, p0, o0);
    model(a, b, s, 12, p1, o1);
    m0.a = a; m0.b = b; m0.signed_mode = s; m0.start = 1'b1;
    @(posedge clk);
    ok = 1'b1;
    for (int j = 0; j <= B_W; j++) begin
      @(negedge clk);
      m0.a = 10'($urandom); m0.b = 10'($urandom); m0.signed_mode = 1'($urandom);
      if (!hold) m0.start = (j == 4);
      ok &= (m0.busy === 1'b1) && (m0.done === 1'b0) &&
            (m1.busy === 1'b1) && (m1.done === 1'b0);
    end
    @(negedge clk);
    chk({tag, "_busy_window"}, 32'(ok), 32'd1);
    chk({tag, "_done_latency"}, {m0.done, m0.busy, m1.done, m1.busy}, 32'b1010);
    chk({tag, "_product20"}, 32'(m0.product), 32'(p0));
    chk({tag, "_overflow20"}, 32'(m0.overflow), 32'(o0));
    chk({tag, "_product12"}, 32'(m1.product), 32'(p1[11:0]));
    chk({tag, "_overflow12"}, 32'(m1.overflow), 32'(o1));
    if (!hold) begin
      m0.start = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, {m0.done, m1.done}, 32'd0);
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    m0.start = 1'b0; m0.a = '0; m0.b = '0; m0.signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {m0.busy, m0.done, m0.overflow, m1.busy, m1.done, m1.overflow}, 32'd0);
    chk("reset_product", {m0.product, m1.product}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op("u_max",     10'd1023,  10'd1023,  1'b0, 1'b0);
    op("s_neg1x5",  10'h3FF,   10'd5,     1'b1, 1'b0);
    op("s_minmin",  10'h200,   10'h200,   1'b1, 1'b0);
    op("u_100x50",  10'd100,   10'd50,    1'b0, 1'b0);
    op("u_60x60",   10'd60,    10'd60,    1'b0, 1'b0);
    op("u_zero",    10'd0,     10'd777,   1'b0, 1'b0);
    op("s_minx1",   10'h200,   10'h001,   1'b1, 1'b1);
    op("b2b_2nd",   10'd123,   10'h3FE,   1'b1, 1'b1);
    op("b2b_3rd",   10'd511,   10'd511,   1'b0, 1'b0);

    // Abort mid-operation: reset 5 cycles after the accepting edge.
    m0.a = 10'd999; m0.b = 10'd999; m0.signed_mode = 1'b0; m0.start = 1'b1;
    @(posedge clk);
    @(negedge clk); m0.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {m0.busy, m0.done, m0.overflow, m1.busy, m1.done, m1.overflow}, 32'd0);
    chk("abort_product", {m0.product, m1.product}, 32'd0);
    ok = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      ok &= (m0.done === 1'b0) && (m1.done === 1'b0) && (m0.busy === 1'b0);
    end
    chk("abort_no_done", 32'(ok), 32'd1);
    op("after_abort", 10'd3, 10'd4, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      op($sformatf("rand%0d", i), 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
    m0.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", {m0.busy, m1.busy, m0.done, m1.done}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
